// File: rtl/traffic_pkg.sv
// Shared light encodings and controller state codes for the intersection controller.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        ST_UNUSED = 3'd7
    } state_e;

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter: cleared on every state change, advanced on tick,
// optionally saturating at dur-1, and flagging expiry of the current duration.
module phase_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       sat_en,
    input  logic [7:0] dur,
    output logic       expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       at_end;

    assign at_end  = (cnt_q == (dur - 8'd1));
    assign expired = tick & at_end;

    // Next count: clear wins, otherwise count ticks unless held at the saturation point.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (tick && !(sat_en && at_end)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road traffic light controller with demand-driven EW phase and pedestrian walk.
//
// state     | meaning
// ALLRED_A  | clearance before NS green
// NS_GREEN  | NS green, held past minimum until EW car or pedestrian demand
// NS_YELLOW | NS yellow
// ALLRED_B  | clearance before EW green or pedestrian walk
// EW_GREEN  | fixed-length EW green
// EW_YELLOW | EW yellow
// PED_WALK  | pedestrian walk, both roads red
module intersection_ctrl #(
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned ALLRED_T   = 1,
    parameter int unsigned EW_GREEN_T = 6,
    parameter int unsigned PED_T      = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase
);
    import traffic_pkg::*;

    localparam logic [7:0] MIN_GREEN_C  = 8'(MIN_GREEN);
    localparam logic [7:0] YELLOW_C     = 8'(YELLOW_T);
    localparam logic [7:0] ALLRED_C     = 8'(ALLRED_T);
    localparam logic [7:0] EW_GREEN_C   = 8'(EW_GREEN_T);
    localparam logic [7:0] PED_C        = 8'(PED_T);

    state_e     state_q;
    state_e     state_d;
    logic       ped_pend_q;
    logic       ped_pend_d;
    logic [7:0] dur;
    logic       expired;

    // Duration of the phase currently being timed.
    always_comb begin
        dur = 8'd1;
        case (state_q)
            ALLRED_A, ALLRED_B:   dur = ALLRED_C;
            NS_GREEN:             dur = MIN_GREEN_C;
            NS_YELLOW, EW_YELLOW: dur = YELLOW_C;
            EW_GREEN:             dur = EW_GREEN_C;
            PED_WALK:             dur = PED_C;
            default:              dur = 8'd1;
        endcase
    end

    phase_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .clear   (state_d != state_q),
        .sat_en  (state_q == NS_GREEN),
        .dur     (dur),
        .expired (expired)
    );

    // Next state and pedestrian latch; entering the walk phase clears a coincident request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ALLRED_A:  if (expired) state_d = NS_GREEN;
            NS_GREEN:  if (expired && (ew_car || ped_pend_q)) state_d = NS_YELLOW;
            NS_YELLOW: if (expired) state_d = ALLRED_B;
            ALLRED_B:  if (expired) state_d = ped_pend_q ? PED_WALK : EW_GREEN;
            EW_GREEN:  if (expired) state_d = EW_YELLOW;
            EW_YELLOW: if (expired) state_d = ALLRED_A;
            PED_WALK:  if (expired) state_d = ALLRED_A;
            default:   state_d = ALLRED_A;
        endcase

        ped_pend_d = ped_pend_q;
        if (state_d == PED_WALK && state_q != PED_WALK) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && state_q != PED_WALK) begin
            ped_pend_d = 1'b1;
        end
    end

    // State and pending-walk registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ALLRED_A;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    // Moore output decode; every unlisted code, including the unused one, shows all red.
    always_comb begin
        ns_light = RED;
        ew_light = RED;
        ped_walk = 1'b0;
        case (state_q)
            NS_GREEN:  ns_light = GREEN;
            NS_YELLOW: ns_light = YELLOW;
            EW_GREEN:  ew_light = GREEN;
            EW_YELLOW: ew_light = YELLOW;
            PED_WALK:  ped_walk = 1'b1;
            default:   ;
        endcase
    end

    assign phase = state_q;

endmodule
